// File: rtl/train_scheduler_pkg.sv
// Shared definitions for the packet-train scheduler and the register map that
// exposes its state: state encodings and default counter/gap widths.
package train_sched_defs;

    localparam int CNT_WIDTH_DFLT = 32;
    localparam int GAP_WIDTH_DFLT = 32;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ       = 3'd1;
    localparam logic [2:0] PKT_GAP   = 3'd2;
    localparam logic [2:0] TRAIN_GAP = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = IDLE,
        ST_REQ       = REQ,
        ST_PKT_GAP   = PKT_GAP,
        ST_TRAIN_GAP = TRAIN_GAP,
        ST_DONE      = DONE
    } state_e;

endpackage

// File: rtl/train_scheduler_if.sv
// Control/status bundle between the register file, the packet generator and
// the train scheduler.
interface train_scheduler_if
    import train_sched_defs::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DFLT,
    parameter int GAP_WIDTH = GAP_WIDTH_DFLT
);
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] train_len;
    logic [CNT_WIDTH-1:0] num_trains;
    logic [GAP_WIDTH-1:0] pkt_gap;
    logic [GAP_WIDTH-1:0] train_gap;
    logic                 gen_req;
    logic                 gen_ack;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pkts_sent;
    logic [CNT_WIDTH-1:0] trains_sent;
    logic [2:0]           state_o;

    modport master (
        output start, abort, train_len, num_trains, pkt_gap, train_gap, gen_ack,
        input  gen_req, busy, done, pkts_sent, trains_sent, state_o
    );

    modport slave (
        input  start, abort, train_len, num_trains, pkt_gap, train_gap, gen_ack,
        output gen_req, busy, done, pkts_sent, trains_sent, state_o
    );

endinterface

// File: rtl/train_scheduler_gap_timer.sv
// Loadable down-counter timing the idle cycles between packets/trains.
// o_expire marks the last gap cycle; o_skip flags a zero gap (no gap state).
module gap_timer #(
    parameter int GAP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [GAP_WIDTH-1:0] i_value,
    output logic                 o_skip,
    output logic                 o_expire
);

    logic [GAP_WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_skip   = (i_value == '0);
    assign o_expire = (r_count == GAP_WIDTH'(1));

endmodule

// File: rtl/train_scheduler.sv
// Packet-train sequencer: issues num_trains x train_len generator requests
// with pkt_gap / train_gap idle cycles, and reports progress counters.
module train_scheduler
    import train_sched_defs::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DFLT,
    parameter int GAP_WIDTH = GAP_WIDTH_DFLT
) (
    input  logic             axi_aclk,
    input  logic             reset,
    train_scheduler_if.slave bus
);

    state_e               r_state;
    state_e               w_next;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_ntrains;
    logic [GAP_WIDTH-1:0] r_pkt_gap;
    logic [GAP_WIDTH-1:0] r_train_gap;
    logic [CNT_WIDTH-1:0] r_idx;
    logic [CNT_WIDTH-1:0] r_pkts;
    logic [CNT_WIDTH-1:0] r_trains;
    logic                 r_acked;

    logic                 w_cfg_empty;
    logic                 w_last_pkt;
    logic                 w_run_end;
    logic [GAP_WIDTH-1:0] w_gap_value;
    logic                 w_gap_skip;
    logic                 w_gap_expire;
    logic                 w_gap_load;
    logic                 w_accept;
    logic                 w_gen_req;
    logic                 w_busy;
    logic                 w_done;

    assign w_cfg_empty = (bus.train_len == '0) || (bus.num_trains == '0);
    assign w_last_pkt  = ((r_idx + 1'b1) == r_len);
    assign w_run_end   = w_last_pkt && ((r_trains + 1'b1) == r_ntrains);
    assign w_gap_value = w_last_pkt ? r_train_gap : r_pkt_gap;

    gap_timer #(.GAP_WIDTH(GAP_WIDTH)) u_gap_timer (
        .clk      (axi_aclk),
        .rst      (reset),
        .i_load   (w_gap_load),
        .i_value  (w_gap_value),
        .o_skip   (w_gap_skip),
        .o_expire (w_gap_expire)
    );

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        w_gen_req  = 1'b0;
        w_accept   = 1'b0;
        w_gap_load = 1'b0;
        w_busy     = (r_state != ST_IDLE);
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_cfg_empty) w_next = ST_DONE;
                    else             w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request is masked for one cycle after each ack: 2-cycle minimum period.
                w_gen_req = !r_acked;
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_gen_req && bus.gen_ack) begin
                    w_accept = 1'b1;
                    if (w_run_end) begin
                        w_next = ST_DONE;
                    end else if (w_gap_skip) begin
                        w_next = ST_REQ;
                    end else begin
                        w_gap_load = 1'b1;
                        if (w_last_pkt) w_next = ST_TRAIN_GAP;
                        else            w_next = ST_PKT_GAP;
                    end
                end
            end
            ST_PKT_GAP, ST_TRAIN_GAP: begin
                if (bus.abort)         w_next = ST_IDLE;
                else if (w_gap_expire) w_next = ST_REQ;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: shadow config registers are reset too, so nothing downstream ever
    // sees X after reset even though they are rewritten on every start.
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_ntrains   <= '0;
            r_pkt_gap   <= '0;
            r_train_gap <= '0;
            r_idx       <= '0;
            r_pkts      <= '0;
            r_trains    <= '0;
            r_acked     <= 1'b0;
        end else begin
            r_acked <= w_accept;
            if (r_state == ST_IDLE && bus.start) begin
                r_len       <= bus.train_len;
                r_ntrains   <= bus.num_trains;
                r_pkt_gap   <= bus.pkt_gap;
                r_train_gap <= bus.train_gap;
                r_idx       <= '0;
                r_pkts      <= '0;
                r_trains    <= '0;
            end else if (w_accept) begin
                r_pkts <= r_pkts + 1'b1;
                if (w_last_pkt) begin
                    r_idx    <= '0;
                    r_trains <= r_trains + 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.gen_req     = w_gen_req;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.pkts_sent   = r_pkts;
    assign bus.trains_sent = r_trains;
    assign bus.state_o     = r_state;

endmodule
